bnn_act_packer: RTL
===================

# bnn_act_packer

Downstream consumer of the XNOR-popcount multiplier's `be_out` result stream. It accumulates 7-bit popcounts over the 64-bit chunks of one neuron and converts the total to a signed dot product. It thresholds that into one binary activation and packs the activations LSB-first into 32-bit words for the next layer or a Wishbone readback register. It sits between `top_bin_mult` and the activation buffer, with valid/ready handshakes on both sides.

## Interface
Parameters:
- `ACC_W`, 16: accumulator and dot-product width, signed.
- `CNT_W`, 8: chunk-counter width; max 255 chunks per neuron.
- `OUT_W`, 32: packed output word width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `in_valid` in 1: popcount beat valid.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `in_pop` in 7: popcount of one 64-bit chunk, 0..64.
- `in_last` in 1: beat is the final chunk of the current neuron.
- `in_flush` in 1: qualified by `in_last`; emit the partial word after this neuron.
- `cfg_threshold` in ACC_W: signed threshold; activation = 1 iff dot >= threshold.
- `out_valid` out 1: packed word available.
- `out_ready` in 1: consumer accepts the word.
- `out_word` out OUT_W: packed activations; bit i = i-th neuron since last emit.
- `out_count` out 6: number of valid bits in `out_word`, 1..32.
- `err_ovf` out 1: sticky; a neuron exceeded 255 chunks.

## Operation
- FSM states:
  - ACCUM: `in_ready`=1.
  - COMPARE: `in_ready`=0; lasts 1 cycle.
  - EMIT: `in_ready`=0; `out_valid`=1.
- ACCUM, accepted beat:
  - Add `sum += min(in_pop,64)`; values above 64 are clamped.
  - Increment `nchunks`.
  - If `in_last`, latch the flush flag and go to COMPARE.
- COMPARE:
  - Compute `dot = 2*sum - 64*nchunks` in ACC_W signed; range ±16320, so no overflow.
  - Activation bit = (dot >= `cfg_threshold`), signed compare; `cfg_threshold` is sampled in this cycle.
  - Write the bit at position `pack_cnt`, then `pack_cnt++`.
  - Clear `sum` and `nchunks`.
  - If `pack_cnt` reaches 32 or flush is latched: copy the packer to the output register, set `out_count`, zero the unused upper bits, clear the packer, and go to EMIT. Otherwise return to ACCUM.
- EMIT: hold `out_word`/`out_count` stable until `out_valid && out_ready`, then go to ACCUM.
- Chunk-count overflow: a beat arriving when `nchunks`=255 and not `in_last` is accepted and ignored, and `err_ovf` is set.
  - A last beat at 255 is also ignored for accumulation but still ends the neuron.
  - `err_ovf` clears only on reset.
- Reset in any state:
  - Go to ACCUM; clear `sum`, `nchunks`, packer, `pack_cnt` and flush flag; the partial word is discarded.
  - Outputs: `in_ready`=1 from the first cycle after reset; `out_valid`=0, `out_word`=0, `out_count`=0, `err_ovf`=0.
- `in_flush` without `in_last` is ignored.

## Timing
- Beat accepted at edge T with `in_last`:
  - COMPARE in cycle T+1.
  - Next beat accepted no earlier than edge T+2.
- Word-completing neuron: `out_valid` rises in cycle T+2; earliest handshake at edge T+2; ACCUM from cycle T+3.
- Throughput per neuron: n chunk beats + 1 COMPARE cycle, plus 1 EMIT cycle per word at minimum.
- `in_ready` is a registered state decode with no combinational path from `out_ready`.
- `out_word` and `out_count` never change while `out_valid`=1.

## Configuration
- `BNN_ACT_DOT_DBG_EN`:
  - Defined: adds outputs `dbg_dot` (ACC_W, signed) and `dbg_dot_valid` (1), both registered. `dbg_dot_valid` is a 1-cycle pulse in cycle T+2 carrying the COMPARE-cycle dot. Both reset to 0.
  - Undefined: ports and registers are absent; all other behaviour is identical.

## Structure
- Package `bnn_pkg`:
  - `POP_W`=7 and `CHUNK_BITS`=64.
  - Typedef `dot_t` (signed ACC_W).
  - FSM state enum `act_state_t` (ACCUM, COMPARE, EMIT).
- Sub-module `bnn_bit_packer`: 32-bit shift/position register with `pack_cnt`, bit-write and clear-on-take. The top level holds the FSM, accumulator and threshold logic.

## Test plan
- Single neuron, two beats pop=40,40, threshold 0, `in_flush`=1:
  - dot = 160 - 128 = 32, bit 1.
  - `out_word`=0x00000001, `out_count`=1, `out_valid` at T+2.
- 32 neurons of one beat each, pops alternating 64 and 0, threshold 0: `out_word`=0x55555555, `out_count`=32, emitted without flush.
- One beat pop=32 with threshold 0 (dot 0, bit 1), then threshold 1 (bit 0): checks the signed boundary compare. Threshold -64 with pop=0: bit 1.
- `out_ready` held 0 for 10 cycles in EMIT: `in_ready`=0 and `out_word` stable throughout; after the handshake, ACCUM the next cycle.
- 256 non-last beats of pop=64, then last:
  - `err_ovf`=1; ignored beats still accepted.
  - dot = 2*16320 - 64*255 = 16320.
- Reset after 5 neurons mid-word: no emit; next flush after 1 neuron gives `out_count`=1 and `err_ovf`=0.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types and constants for the binary-activation packer slice.
package bnn_pkg;

  localparam int POP_W      = 7;
  localparam int CHUNK_BITS = 64;
  localparam int ACC_W_DEF  = 16;

  typedef logic signed [ACC_W_DEF-1:0] dot_t;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    COMPARE = 2'd1,
    EMIT    = 2'd2
  } act_state_t;

  // A 7-bit popcount can encode up to 127; anything above a full chunk is clamped.
  function automatic logic [POP_W-1:0] clamp_pop(input logic [POP_W-1:0] pop);
    if (pop > 7'd64) begin
      clamp_pop = 7'd64;
    end else begin
      clamp_pop = pop;
    end
  endfunction

endpackage

// File: rtl/bnn_bit_packer.sv
// LSB-first activation bit packer: writes one bit at the current position and
// clears itself when the top level takes the completed word.
module bnn_bit_packer #(
  parameter int OUT_W = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             wr_bit,
  input  logic             take,
  output logic [OUT_W-1:0] word_next,
  output logic [CNT_W-1:0] cnt_next,
  output logic             full_next
);

  logic [OUT_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // word_next/cnt_next include the bit being written this cycle so the
  // top level can copy a completed word without waiting a cycle.
  always_comb begin
    word_next = word_q;
    cnt_next  = cnt_q;
    if (wr_en) begin
      word_next = word_q | ({{(OUT_W-1){1'b0}}, wr_bit} << cnt_q);
      cnt_next  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      word_next = word_q;
      cnt_next  = cnt_q;
    end
    full_next = (cnt_next == CNT_W'(OUT_W));
    if (take) begin
      word_d = '0;
      cnt_d  = '0;
    end else begin
      word_d = word_next;
      cnt_d  = cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/bnn_act_packer.sv
// Accumulates per-neuron popcounts, thresholds the signed dot product and packs
// activations into words. Optional debug dot output under BNN_ACT_DOT_DBG_EN.
module bnn_act_packer
  import bnn_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8,
  parameter int OUT_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [POP_W-1:0]        in_pop,
  input  logic                    in_last,
  input  logic                    in_flush,
  input  logic signed [ACC_W-1:0] cfg_threshold,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_word,
  output logic [5:0]              out_count,
  output logic                    err_ovf
`ifdef BNN_ACT_DOT_DBG_EN
  ,
  output logic signed [ACC_W-1:0] dbg_dot,
  output logic                    dbg_dot_valid
`endif
);

  localparam int PCNT_W   = 6;
  localparam int CHUNK_SH = $clog2(CHUNK_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  act_state_t state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] nchunks_q, nchunks_d;
  logic             flush_q, flush_d;
  logic [OUT_W-1:0] out_word_q, out_word_d;
  logic [5:0]       out_count_q, out_count_d;
  logic             err_ovf_q, err_ovf_d;

  logic                    beat_acc_s;
  logic [POP_W-1:0]        pop_clamped_s;
  logic signed [ACC_W-1:0] dot_s;
  logic                    act_bit_s;
  logic                    emit_s;
  logic                    pack_wr_s;
  logic [OUT_W-1:0]        pack_word_s;
  logic [PCNT_W-1:0]       pack_cnt_next_s;
  logic                    pack_full_s;

  assign beat_acc_s    = in_valid && in_ready;
  assign pop_clamped_s = clamp_pop(in_pop);
  // dot = matches - mismatches = 2*sum - 64*nchunks; fits ACC_W for <=255 chunks.
  assign dot_s = $signed((sum_q << 1) - ({{(ACC_W-CNT_W){1'b0}}, nchunks_q} << CHUNK_SH));
  assign act_bit_s = (dot_s >= cfg_threshold);
  assign emit_s    = (state_q == COMPARE) && (pack_full_s || flush_q);

  bnn_bit_packer #(.OUT_W(OUT_W), .CNT_W(PCNT_W)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (pack_wr_s),
    .wr_bit    (act_bit_s),
    .take      (emit_s),
    .word_next (pack_word_s),
    .cnt_next  (pack_cnt_next_s),
    .full_next (pack_full_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (beat_acc_s && in_last) state_d = COMPARE; else state_d = ACCUM;
      COMPARE: if (emit_s) state_d = EMIT; else state_d = ACCUM;
      EMIT:    if (out_ready) state_d = ACCUM; else state_d = EMIT;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    pack_wr_s = 1'b0;
    case (state_q)
      ACCUM:   in_ready  = 1'b1;
      COMPARE: pack_wr_s = 1'b1;
      EMIT:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  always_comb begin
    sum_d       = sum_q;
    nchunks_d   = nchunks_q;
    flush_d     = flush_q;
    out_word_d  = out_word_q;
    out_count_d = out_count_q;
    err_ovf_d   = err_ovf_q;
    case (state_q)
      ACCUM: begin
        if (beat_acc_s) begin
          // A saturated chunk counter freezes the accumulator for the rest of the neuron.
          if (nchunks_q == CNT_MAX) begin
            if (!in_last) err_ovf_d = 1'b1; else err_ovf_d = err_ovf_q;
          end else begin
            sum_d     = sum_q + {{(ACC_W-POP_W){1'b0}}, pop_clamped_s};
            nchunks_d = nchunks_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (in_last) flush_d = in_flush; else flush_d = flush_q;
        end else begin
          sum_d = sum_q;
        end
      end
      COMPARE: begin
        sum_d     = '0;
        nchunks_d = '0;
        flush_d   = 1'b0;
        if (emit_s) begin
          out_word_d  = pack_word_s;
          out_count_d = pack_cnt_next_s;
        end else begin
          out_word_d  = out_word_q;
          out_count_d = out_count_q;
        end
      end
      EMIT:    sum_d = sum_q;
      default: sum_d = sum_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q       <= '0;
      nchunks_q   <= '0;
      flush_q     <= 1'b0;
      out_word_q  <= '0;
      out_count_q <= 6'd0;
      err_ovf_q   <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      nchunks_q   <= nchunks_d;
      flush_q     <= flush_d;
      out_word_q  <= out_word_d;
      out_count_q <= out_count_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign out_word  = out_word_q;
  assign out_count = out_count_q;
  assign err_ovf   = err_ovf_q;

`ifdef BNN_ACT_DOT_DBG_EN
  logic signed [ACC_W-1:0] dbg_dot_q, dbg_dot_d;
  logic                    dbg_dot_valid_q, dbg_dot_valid_d;

  always_comb begin
    if (state_q == COMPARE) begin
      dbg_dot_d       = dot_s;
      dbg_dot_valid_d = 1'b1;
    end else begin
      dbg_dot_d       = dbg_dot_q;
      dbg_dot_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_dot_q       <= '0;
      dbg_dot_valid_q <= 1'b0;
    end else begin
      dbg_dot_q       <= dbg_dot_d;
      dbg_dot_valid_q <= dbg_dot_valid_d;
    end
  end

  assign dbg_dot       = dbg_dot_q;
  assign dbg_dot_valid = dbg_dot_valid_q;
`endif

endmodule
